// File: rtl/control_pulse_generator_pkg.sv
// cp_pkg: shared constants and the opcode/step -> control-pulse decode for
// control_pulse_generator.
//   MAX_TP        : width of the timing-pulse bus from sequence_generator
//   OP_*          : opcode encodings (OP_NOOP marks an idle memory cycle)
//   CP_*          : bit positions inside the 8-bit cp strobe vector
//   state_e       : SYNC (hunting for step 1) / RUN (tracking step order)
//   cp_decode()   : pure mapping (opcode, step) -> cp strobes
package cp_pkg;

  localparam int unsigned MAX_TP = 11;

  localparam logic [2:0] OP_TC   = 3'd0;
  localparam logic [2:0] OP_CA   = 3'd1;
  localparam logic [2:0] OP_CS   = 3'd2;
  localparam logic [2:0] OP_TS   = 3'd3;
  localparam logic [2:0] OP_AD   = 3'd4;
  localparam logic [2:0] OP_XCH  = 3'd5;
  localparam logic [2:0] OP_MASK = 3'd6;
  localparam logic [2:0] OP_NOOP = 3'd7;

  localparam int unsigned CP_RSC  = 0;
  localparam int unsigned CP_RG   = 1;
  localparam int unsigned CP_RA   = 2;
  localparam int unsigned CP_WA   = 3;
  localparam int unsigned CP_WG   = 4;
  localparam int unsigned CP_ADD  = 5;
  localparam int unsigned CP_COMP = 6;
  localparam int unsigned CP_WZ   = 7;

  typedef enum logic {
    SYNC,
    RUN
  } state_e;

  function automatic logic [7:0] cp_decode(input logic [2:0] op, input logic [3:0] step);
    logic [7:0] cp;
    logic       rd_g;
    cp   = '0;
    // Opcodes that read G at step 2 are exactly those that write A at step 4.
    rd_g = (op == OP_CA) || (op == OP_CS) || (op == OP_AD) ||
           (op == OP_XCH) || (op == OP_MASK);
    if (op != OP_NOOP) begin
      case (step)
        4'd1: cp[CP_RSC] = 1'b1;
        4'd2: cp[CP_RG]  = rd_g;
        4'd3: cp[CP_RA]  = (op == OP_TS) || (op == OP_AD) ||
                           (op == OP_XCH) || (op == OP_MASK);
        4'd4: begin
          cp[CP_WA]   = rd_g;
          cp[CP_COMP] = (op == OP_CS);
          cp[CP_ADD]  = (op == OP_AD);
          cp[CP_WZ]   = (op == OP_TC);
        end
        4'd5: cp[CP_WG]  = (op == OP_TS) || (op == OP_XCH);
        default: cp = '0;
      endcase
    end
    return cp;
  endfunction

endpackage

// File: rtl/control_pulse_generator_if.sv
// control_pulse_generator_if: bundles the timing-pulse inputs, instruction
// inputs and control-pulse outputs of control_pulse_generator.
//   master : drives tp/run/op_in/op_valid, observes the outputs (testbench,
//            upstream glue)
//   slave  : the control_pulse_generator side
interface control_pulse_generator_if;

  logic [cp_pkg::MAX_TP-1:0] tp;
  logic                      run;
  logic [2:0]                op_in;
  logic                      op_valid;
  logic [7:0]                cp;
  logic                      inst_done;
  logic                      seq_err;
  logic [2:0]                cur_op;
  logic                      busy;

  modport master (
    output tp, run, op_in, op_valid,
    input  cp, inst_done, seq_err, cur_op, busy
  );

  modport slave (
    input  tp, run, op_in, op_valid,
    output cp, inst_done, seq_err, cur_op, busy
  );

endinterface

// File: rtl/control_pulse_generator_tp_edge_detect.sv
// tp_edge_detect: turns the level timing pulses into rising-edge step events.
//   clk, rst : system clock, synchronous active-high reset
//   tp       : timing pulses, bit k-1 = tpk
//   step     : index k of the lowest rising bit this cycle, 0 when none
//   multi    : more than one bit rose this cycle
//   any      : at least one bit rose this cycle
module tp_edge_detect
  import cp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [MAX_TP-1:0] tp,
  output logic [3:0]        step,
  output logic              multi,
  output logic              any
);

  logic [MAX_TP-1:0] tp_s_q, tp_s_d;
  logic [MAX_TP-1:0] tp_q, tp_d;
  logic [MAX_TP-1:0] blk_q, blk_d;
  logic [MAX_TP-1:0] ev;

  // tp_s_q is the posedge sample of tp and tp_q the sample before it, so the
  // event is seen one cycle after the first sample and the registered outputs
  // land one cycle later again. blk_q masks any bit that was already high
  // across reset until it has been seen low once.
  always_comb begin
    tp_s_d = tp;
    tp_d   = tp_s_q;
    blk_d  = blk_q & tp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tp_s_q <= '0;
      tp_q   <= '0;
      blk_q  <= '1;
    end else begin
      tp_s_q <= tp_s_d;
      tp_q   <= tp_d;
      blk_q  <= blk_d;
    end
  end

  always_comb begin
    ev    = tp_s_q & ~tp_q & ~blk_q;
    any   = |ev;
    multi = |(ev & (ev - {{(MAX_TP-1){1'b0}}, 1'b1}));
    step  = '0;
    for (int unsigned i = MAX_TP; i > 0; i--) begin
      if (ev[i-1]) step = 4'(i);
    end
  end

endmodule

// File: rtl/control_pulse_generator.sv
// control_pulse_generator: follows the timing pulses of sequence_generator and
// issues the register-transfer strobes of the instruction latched at step 1.
//   NUM_TP : timing pulses per memory cycle (5..11)
//   clk    : system clock, posedge
//   rst    : synchronous active-high reset
//   bus    : slave side of control_pulse_generator_if
//            tp/run/op_in/op_valid in; cp, inst_done, seq_err, cur_op, busy
//            out, all registered
module control_pulse_generator
  import cp_pkg::*;
#(
  parameter int unsigned NUM_TP = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  control_pulse_generator_if.slave    bus
);

  localparam logic [3:0] LAST_STEP = 4'(NUM_TP);

  logic [3:0] ev_step;
  logic       ev_multi;
  logic       ev_any;

  state_e     state_q, state_d;
  logic [3:0] exp_q, exp_d;
  logic [7:0] cp_q, cp_d;
  logic       inst_done_q, inst_done_d;
  logic       seq_err_q, seq_err_d;
  logic [2:0] cur_op_q, cur_op_d;
  logic       busy_q, busy_d;

  logic [2:0] latch_op;
  logic       single;
  logic       start;
  logic       order_err;

  tp_edge_detect u_edge (
    .clk   (clk),
    .rst   (rst),
    .tp    (bus.tp),
    .step  (ev_step),
    .multi (ev_multi),
    .any   (ev_any)
  );

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    cp_d        = '0;
    inst_done_d = 1'b0;
    seq_err_d   = 1'b0;
    cur_op_d    = cur_op_q;
    // busy stays up through the inst_done strobe cycle and drops after it;
    // a step 1 in the same cycle re-raises it below.
    busy_d      = busy_q & ~inst_done_q;

    latch_op  = (bus.op_valid && bus.run) ? bus.op_in : OP_NOOP;
    single    = ev_any && !ev_multi;
    start     = 1'b0;
    order_err = 1'b0;

    case (state_q)
      SYNC: begin
        start = single && (ev_step == 4'd1);
      end
      RUN: begin
        if (ev_any) begin
          order_err = ev_multi || (ev_step != exp_q) || (ev_step > LAST_STEP);
          start     = !order_err && (ev_step == 4'd1);
        end
      end
      default: begin
        state_d = SYNC;
      end
    endcase

    if (order_err) begin
      seq_err_d = 1'b1;
      busy_d    = 1'b0;
      cur_op_d  = OP_NOOP;
      state_d   = SYNC;
      exp_d     = 4'd1;
    end else if (start) begin
      cur_op_d = latch_op;
      cp_d     = cp_decode(latch_op, 4'd1);
      busy_d   = (latch_op != OP_NOOP);
      state_d  = RUN;
      exp_d    = 4'd2;
    end else if (state_q == RUN && ev_any) begin
      cp_d = cp_decode(cur_op_q, ev_step);
      if (ev_step == LAST_STEP) begin
        exp_d       = 4'd1;
        inst_done_d = (cur_op_q != OP_NOOP);
      end else begin
        exp_d = ev_step + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SYNC;
      exp_q       <= 4'd1;
      cp_q        <= '0;
      inst_done_q <= 1'b0;
      seq_err_q   <= 1'b0;
      cur_op_q    <= OP_NOOP;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      cp_q        <= cp_d;
      inst_done_q <= inst_done_d;
      seq_err_q   <= seq_err_d;
      cur_op_q    <= cur_op_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cp        = cp_q;
  assign bus.inst_done = inst_done_q;
  assign bus.seq_err   = seq_err_q;
  assign bus.cur_op    = cur_op_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_control_pulse_generator.sv
module tb_control_pulse_generator;
  import cp_pkg::*;

  localparam int unsigned NTP = 5;
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  control_pulse_generator_if bus ();

  control_pulse_generator #(.NUM_TP(NTP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Expected cp per opcode (TC..MASK) for steps 1..5, written out by hand.
  logic [7:0] exp_tab [0:6][0:4] = '{
    '{8'h01, 8'h00, 8'h00, 8'h80, 8'h00},  // TC
    '{8'h01, 8'h02, 8'h00, 8'h08, 8'h00},  // CA
    '{8'h01, 8'h02, 8'h00, 8'h48, 8'h00},  // CS
    '{8'h01, 8'h00, 8'h04, 8'h00, 8'h10},  // TS
    '{8'h01, 8'h02, 8'h04, 8'h28, 8'h00},  // AD
    '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10},  // XCH
    '{8'h01, 8'h02, 8'h04, 8'h08, 8'h00}   // MASK
  };

  typedef struct {
    logic [10:0] tp;
    logic        r;
    logic [2:0]  op;
    logic        v;
    logic [7:0]  cp;
    logic        done;
    logic        err;
    logic [2:0]  cur;
    logic        busy;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [10:0] t, input logic r, input logic [2:0] o,
                              input logic v, input logic [7:0] c, input logic d,
                              input logic e, input logic [2:0] cu, input logic b);
    vec_t x;
    x.tp = t; x.r = r; x.op = o; x.v = v;
    x.cp = c; x.done = d; x.err = e; x.cur = cu; x.busy = b;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
  endtask

  task automatic chk_outs(input string tag, input logic [7:0] c, input logic d, input logic e,
                          input logic [2:0] cu, input logic b);
    chk({tag, " cp"},        32'(bus.cp),        32'(c));
    chk({tag, " inst_done"}, 32'(bus.inst_done), 32'(d));
    chk({tag, " seq_err"},   32'(bus.seq_err),   32'(e));
    chk({tag, " cur_op"},    32'(bus.cur_op),    32'(cu));
    chk({tag, " busy"},      32'(bus.busy),      32'(b));
  endtask

  // Called at a negedge: drives one memory-cycle slot held for 3 cycles,
  // checks the strobe cycle and then that the strobes last one cycle only.
  task automatic run_slot(input string tag, input logic [10:0] t, input logic r,
                          input logic [2:0] o, input logic v, input logic [7:0] c,
                          input logic d, input logic e, input logic [2:0] cu, input logic b);
    bus.tp = t; bus.run = r; bus.op_in = o; bus.op_valid = v;
    @(negedge clk);
    @(negedge clk);
    chk_outs(tag, c, d, e, cu, b);
    @(negedge clk);
    chk_outs({tag, "+1"}, 8'h00, F, F, cu, b && !d);
  endtask

  task automatic do_reset();
    bus.tp = '0; bus.run = F; bus.op_in = 3'd0; bus.op_valid = F;
    rst = T;
    @(negedge clk);
    @(negedge clk);
    rst = F;
    @(negedge clk);
  endtask

  // Behavioural reference model for the random phase.
  logic        m_sync;
  int          m_exp;
  logic [2:0]  m_op;
  logic        m_busy;
  logic [10:0] m_prev;
  logic [7:0]  e_cp;
  logic        e_done, e_err;

  task automatic model_reset();
    m_sync = T; m_exp = 1; m_op = OP_NOOP; m_busy = F; m_prev = '0;
  endtask

  task automatic model_apply(input logic [10:0] tpn, input logic r, input logic [2:0] o,
                             input logic v);
    logic [10:0] ev;
    int n, k;
    ev = tpn & ~m_prev;
    m_prev = tpn;
    n = $countones(ev);
    k = 0;
    for (int i = 10; i >= 0; i--) if (ev[i]) k = i + 1;
    e_cp = 8'h00; e_done = F; e_err = F;
    if (n == 0) return;
    if (!m_sync && (n > 1 || k != m_exp || k > int'(NTP))) begin
      e_err = T; m_busy = F; m_op = OP_NOOP; m_sync = T; m_exp = 1;
    end else if (n == 1 && k == 1 && (m_sync || m_exp == 1)) begin
      m_op   = (v && r) ? o : OP_NOOP;
      m_busy = (m_op != OP_NOOP);
      e_cp   = (m_op != OP_NOOP) ? 8'h01 : 8'h00;
      m_sync = F;
      m_exp  = 2;
    end else if (!m_sync) begin
      e_cp = (m_op != OP_NOOP && k <= 5) ? exp_tab[m_op][k-1] : 8'h00;
      if (k == int'(NTP)) begin
        m_exp  = 1;
        e_done = (m_op != OP_NOOP);
      end else begin
        m_exp = k + 1;
      end
    end
  endtask

  initial begin
    vec_t x;
    logic [10:0] t;
    logic        r, v;
    logic [2:0]  o;
    int unsigned sel, b1, b2;

    // AD, then XCH and TS back-to-back
    vt.push_back(mk(11'h001, T, 3'd4, T, 8'h01, F, F, 3'd4, T));
    vt.push_back(mk(11'h002, T, 3'd0, T, 8'h02, F, F, 3'd4, T));
    vt.push_back(mk(11'h004, T, 3'd0, T, 8'h04, F, F, 3'd4, T));
    vt.push_back(mk(11'h008, T, 3'd0, T, 8'h28, F, F, 3'd4, T));
    vt.push_back(mk(11'h010, T, 3'd0, T, 8'h00, T, F, 3'd4, T));
    vt.push_back(mk(11'h001, T, 3'd5, T, 8'h01, F, F, 3'd5, T));
    vt.push_back(mk(11'h002, T, 3'd0, T, 8'h02, F, F, 3'd5, T));
    vt.push_back(mk(11'h004, T, 3'd0, T, 8'h04, F, F, 3'd5, T));
    vt.push_back(mk(11'h008, T, 3'd0, T, 8'h08, F, F, 3'd5, T));
    vt.push_back(mk(11'h010, T, 3'd0, T, 8'h10, T, F, 3'd5, T));
    vt.push_back(mk(11'h001, T, 3'd3, T, 8'h01, F, F, 3'd3, T));
    vt.push_back(mk(11'h002, T, 3'd0, T, 8'h00, F, F, 3'd3, T));
    vt.push_back(mk(11'h004, T, 3'd0, T, 8'h04, F, F, 3'd3, T));
    vt.push_back(mk(11'h008, T, 3'd0, T, 8'h00, F, F, 3'd3, T));
    vt.push_back(mk(11'h010, T, 3'd0, T, 8'h10, T, F, 3'd3, T));
    // op_valid low at step 1: whole cycle is NOOP
    vt.push_back(mk(11'h001, T, 3'd2, F, 8'h00, F, F, 3'd7, F));
    vt.push_back(mk(11'h002, T, 3'd2, F, 8'h00, F, F, 3'd7, F));
    vt.push_back(mk(11'h004, T, 3'd2, F, 8'h00, F, F, 3'd7, F));
    vt.push_back(mk(11'h008, T, 3'd2, F, 8'h00, F, F, 3'd7, F));
    vt.push_back(mk(11'h010, T, 3'd2, F, 8'h00, F, F, 3'd7, F));
    // skipped tp3, then ignored pulses, then resume
    vt.push_back(mk(11'h001, T, 3'd1, T, 8'h01, F, F, 3'd1, T));
    vt.push_back(mk(11'h002, T, 3'd1, T, 8'h02, F, F, 3'd1, T));
    vt.push_back(mk(11'h008, T, 3'd1, T, 8'h00, F, T, 3'd7, F));
    vt.push_back(mk(11'h010, T, 3'd1, T, 8'h00, F, F, 3'd7, F));
    vt.push_back(mk(11'h002, T, 3'd1, T, 8'h00, F, F, 3'd7, F));
    vt.push_back(mk(11'h001, T, 3'd6, T, 8'h01, F, F, 3'd6, T));
    vt.push_back(mk(11'h002, T, 3'd6, T, 8'h02, F, F, 3'd6, T));
    // tp2 and tp3 rise together while tp3 is expected
    vt.push_back(mk(11'h000, T, 3'd6, T, 8'h00, F, F, 3'd6, T));
    vt.push_back(mk(11'h006, T, 3'd6, T, 8'h00, F, T, 3'd7, F));
    // run low at step 1 is NOOP as well
    vt.push_back(mk(11'h001, F, 3'd4, T, 8'h00, F, F, 3'd7, F));
    vt.push_back(mk(11'h002, F, 3'd4, T, 8'h00, F, F, 3'd7, F));
    vt.push_back(mk(11'h004, F, 3'd4, T, 8'h00, F, F, 3'd7, F));
    vt.push_back(mk(11'h008, F, 3'd4, T, 8'h00, F, F, 3'd7, F));
    vt.push_back(mk(11'h010, F, 3'd4, T, 8'h00, F, F, 3'd7, F));
    // CA cycle up to step 2; reset lands at step 3 below
    vt.push_back(mk(11'h001, T, 3'd1, T, 8'h01, F, F, 3'd1, T));
    vt.push_back(mk(11'h002, T, 3'd1, T, 8'h02, F, F, 3'd1, T));

    bus.tp = '0; bus.run = F; bus.op_in = 3'd0; bus.op_valid = F;
    rst = T;
    @(negedge clk);
    @(negedge clk);
    chk_outs("reset", 8'h00, F, F, 3'd7, F);
    rst = F;
    @(negedge clk);

    for (int i = 0; i < vt.size(); i++) begin
      x = vt[i];
      run_slot($sformatf("v%0d", i), x.tp, x.r, x.op, x.v, x.cp, x.done, x.err, x.cur, x.busy);
    end

    // rst for one cycle as tp3 of the CA cycle rises
    bus.tp = 11'h004; rst = T;
    @(negedge clk);
    rst = F;
    chk_outs("midrst", 8'h00, F, F, 3'd7, F);
    @(negedge clk);
    chk_outs("midrst held tp3", 8'h00, F, F, 3'd7, F);
    @(negedge clk);
    chk_outs("midrst held tp3b", 8'h00, F, F, 3'd7, F);
    run_slot("midrst tp4", 11'h008, T, 3'd1, T, 8'h00, F, F, 3'd7, F);
    run_slot("midrst tp5", 11'h010, T, 3'd1, T, 8'h00, F, F, 3'd7, F);
    run_slot("tc s1", 11'h001, T, 3'd0, T, 8'h01, F, F, 3'd0, T);
    run_slot("tc s2", 11'h002, T, 3'd0, T, 8'h00, F, F, 3'd0, T);
    run_slot("tc s3", 11'h004, T, 3'd0, T, 8'h00, F, F, 3'd0, T);
    run_slot("tc s4", 11'h008, T, 3'd0, T, 8'h80, F, F, 3'd0, T);
    run_slot("tc s5", 11'h010, T, 3'd0, T, 8'h00, T, F, 3'd0, T);

    // randomized phase against the reference model
    do_reset();
    model_reset();
    for (int s = 0; s < 600; s++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5) begin
        t = 11'h001 << (m_exp - 1);
      end else if (sel == 6) begin
        t = '0;
      end else if (sel == 7) begin
        t = 11'h001 << $urandom_range(0, 10);
      end else if (sel == 8) begin
        b1 = $urandom_range(0, 10);
        b2 = (b1 + $urandom_range(1, 10)) % 11;
        t  = (11'h001 << b1) | (11'h001 << b2);
      end else begin
        t = m_prev;
      end
      r = ($urandom_range(0, 7) != 0);
      v = ($urandom_range(0, 7) != 0);
      o = 3'($urandom_range(0, 7));
      model_apply(t, r, o, v);
      run_slot($sformatf("rnd%0d", s), t, r, o, v, e_cp, e_done, e_err, m_op, m_busy);
      if (e_done) m_busy = F;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
